// File: rtl/s35932_pkg.sv
// Shared definitions for the s35932 DATA_9 signature checker.
// Holds the session FSM encoding and the default MISR constants.
package s35932_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/s35932_misr.sv
// Multiple-input signature register for the DATA_9 bus.
// load reseeds the register; shift_en folds one data word in.
module s35932_misr
    import s35932_pkg::*;
#(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0]   SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             CK,
    input  logic             RESET,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] signature
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    // Next signature: reseed, fold in one word, or hold.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (shift_en) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0}
                  ^ (sig_q[WIDTH-1] ? POLY : '0)
                  ^ data_in;
        end
    end

    // Signature register, reset back to the seed.
    always_ff @(posedge CK) begin
        if (RESET) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/s35932_data9_misr_checker.sv
// Session controller that compacts a counted run of DATA_9 words
// into a MISR and compares the result against a golden signature.
module s35932_data9_misr_checker
    import s35932_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             CK,
    input  logic             RESET,
    input  logic             TM0,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [WIDTH-1:0] golden,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic             pass_q, pass_d;
    logic             load;
    logic             accept;

    assign load   = (state_q == ST_IDLE) && start;
    assign accept = (state_q == ST_COMPACT) && data_valid && TM0;

    s35932_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .CK        (CK),
        .RESET     (RESET),
        .load      (load),
        .shift_en  (accept),
        .data_in   (data_in),
        .signature (signature)
    );

    // Session sequencing: count accepted words, then compare once.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        golden_d = golden_q;
        pass_d   = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d    = num_words;
                    golden_d = golden;
                    pass_d   = 1'b0;
                    state_d  = (num_words == '0) ? ST_COMPARE
                                                 : ST_COMPACT;
                end
            end
            ST_COMPACT: begin
                if (accept) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_COMPARE;
                    end
                end
            end
            ST_COMPARE: begin
                pass_d  = (signature == golden_q);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any session in progress.
    always_ff @(posedge CK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

    assign busy = (state_q == ST_COMPACT) || (state_q == ST_COMPARE);
    assign done = (state_q == ST_DONE);
    assign pass = pass_q;

endmodule

// File: tb/tb_s35932_data9_misr_checker.sv
// Self-checking bench for the DATA_9 MISR checker.
// Table vectors, directed corner sequences and random sessions.
module tb_s35932_data9_misr_checker;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;
    localparam int          MAXB = 512;

    logic        CK = 1'b0;
    logic        RESET = 1'b1;
    logic        TM0 = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_words = '0;
    logic [31:0] golden = '0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        busy, done, pass;
    logic [31:0] signature;

    int checks = 0;
    int errors = 0;

    logic [31:0] data_a [MAXB];
    logic        tm_a   [MAXB];

    typedef struct {
        int          n;
        logic [31:0] d;
        logic [31:0] g;
        logic        exp_pass;
        logic [31:0] exp_sig;
    } vec_t;

    vec_t vecs [6];

    s35932_data9_misr_checker dut (
        .CK         (CK),
        .RESET      (RESET),
        .TM0        (TM0),
        .start      (start),
        .num_words  (num_words),
        .golden     (golden),
        .data_valid (data_valid),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    always #5 CK = ~CK;

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: polynomial division step applied to each word the
    // checker should accept, stopping after n accepted words.
    function automatic logic [31:0] model(input int n, input int nv);
        logic [31:0] s;
        int          acc;
        s   = SEED;
        acc = 0;
        for (int i = 0; i < nv; i++) begin
            if (tm_a[i] && acc < n) begin
                s = (s << 1) ^ ((s >> 31) != 0 ? POLY : 32'h0) ^ data_a[i];
                acc++;
            end
        end
        return s;
    endfunction

    // Start a session, play nv beats, then wait for done.
    task automatic run(input int n, input logic [31:0] g, input int nv,
                       output logic got_pass, output logic [31:0] got_sig,
                       output int lat);
        start     = 1'b1;
        num_words = 16'(n);
        golden    = g;
        tick();
        start = 1'b0;
        for (int i = 0; i < nv; i++) begin
            data_valid = 1'b1;
            data_in    = data_a[i];
            TM0        = tm_a[i];
            tick();
        end
        data_valid = 1'b0;
        TM0        = 1'b1;
        lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        got_pass = pass;
        got_sig  = signature;
        tick();
    endtask

    logic        gp;
    logic [31:0] gs;
    logic [31:0] exp_s;
    int          lat;
    int          nv;
    int          acc;
    int          n;
    int          seen;

    initial begin
        vecs[0] = '{0, 32'h0,        32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
        vecs[1] = '{0, 32'h0,        32'h00000000, 1'b0, 32'hFFFFFFFF};
        vecs[2] = '{1, 32'h0,        32'hFB3EE249, 1'b1, 32'hFB3EE249};
        vecs[3] = '{1, 32'h0,        32'h00000000, 1'b0, 32'hFB3EE249};
        vecs[4] = '{1, 32'hFFFFFFFF, 32'h04C11DB6, 1'b1, 32'h04C11DB6};
        vecs[5] = '{1, 32'hFB3EE249, 32'h00000000, 1'b1, 32'h00000000};

        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        chk("rst_sig", signature, SEED);
        RESET = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            data_a[0] = vecs[v].d;
            tm_a[0]   = 1'b1;
            run(vecs[v].n, vecs[v].g, vecs[v].n, gp, gs, lat);
            chk($sformatf("vec%0d_pass", v), 32'(gp), 32'(vecs[v].exp_pass));
            chk($sformatf("vec%0d_sig", v), gs, vecs[v].exp_sig);
            chk($sformatf("vec%0d_lat", v), lat, 1);
        end

        for (int i = 0; i < 6; i++) begin
            data_a[i] = $urandom;
            tm_a[i]   = 1'b1;
        end
        tm_a[1] = 1'b0;
        tm_a[4] = 1'b0;
        exp_s = model(4, 6);
        run(4, exp_s, 6, gp, gs, lat);
        chk("tm0_sig", gs, exp_s);
        chk("tm0_pass", 32'(gp), 32'h1);
        chk("tm0_lat", lat, 1);

        for (int i = 0; i < 8; i++) begin
            data_a[i] = $urandom;
            tm_a[i]   = 1'b1;
        end
        start     = 1'b1;
        num_words = 16'd8;
        golden    = 32'h0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data_in    = data_a[i];
            tick();
        end
        data_valid = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'h1);
        RESET = 1'b1;
        data_valid = 1'b1;
        tick();
        RESET = 1'b0;
        data_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_sig", signature, SEED);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen++;
            tick();
        end
        chk("abort_nodone", seen, 0);
        exp_s = model(8, 8);
        run(8, exp_s, 8, gp, gs, lat);
        chk("after_abort_pass", 32'(gp), 32'h1);

        data_a[0] = 32'h12345678;
        tm_a[0]   = 1'b1;
        exp_s = model(1, 1);
        start     = 1'b1;
        num_words = 16'd1;
        golden    = exp_s;
        tick();
        chk("b2b_busy_compact", 32'(busy), 32'h1);
        num_words = 16'd5;
        golden    = 32'h0;
        data_valid = 1'b1;
        data_in    = data_a[0];
        tick();
        data_valid = 1'b0;
        chk("b2b_sig", signature, exp_s);
        chk("b2b_busy_compare", 32'(busy), 32'h1);
        tick();
        chk("b2b_done", 32'(done), 32'h1);
        chk("b2b_pass", 32'(pass), 32'h1);
        num_words = 16'd0;
        golden    = SEED;
        tick();
        chk("b2b_idle_done", 32'(done), 32'h0);
        chk("b2b_idle_busy", 32'(busy), 32'h0);
        tick();
        start = 1'b0;
        chk("b2b_fresh_sig", signature, SEED);
        chk("b2b_fresh_busy", 32'(busy), 32'h1);
        tick();
        chk("b2b2_done", 32'(done), 32'h1);
        chk("b2b2_pass", 32'(pass), 32'h1);
        tick();

        for (int s = 0; s < 1000; s++) begin
            n   = $urandom_range(0, 64);
            nv  = 0;
            acc = 0;
            while (acc < n) begin
                data_a[nv] = $urandom;
                tm_a[nv]   = (nv >= 400) || ($urandom_range(0, 7) != 0);
                if (tm_a[nv]) acc++;
                nv++;
            end
            exp_s = model(n, nv);
            if (s % 2 == 0) begin
                run(n, exp_s, nv, gp, gs, lat);
                chk($sformatf("rnd%0d_pass", s), 32'(gp), 32'h1);
            end else begin
                run(n, exp_s ^ (32'h1 << $urandom_range(0, 31)), nv,
                    gp, gs, lat);
                chk($sformatf("rnd%0d_fail", s), 32'(gp), 32'h0);
            end
            chk($sformatf("rnd%0d_sig", s), gs, exp_s);
            chk($sformatf("rnd%0d_lat", s), lat, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/s35932_data9_misr_checker.md
S35932_DATA9_MISR_CHECKER -- requirements
Module: s35932_data9_misr_checker

Interface
REQ-001 Parameter WIDTH, default 32: DATA_9 bus width, bits DATA_9_0..DATA_9_31 packed LSB-first.
REQ-002 Parameter CNT_W, default 16: width of the word-count register.
REQ-003 Parameter POLY, default 32'h04C11DB7: MISR feedback polynomial.
REQ-004 Parameter SEED, default 32'hFFFFFFFF: MISR initial value.
REQ-005 CK  input  1  single clock; all state updates on its rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 TM0  input  1  test-mode select; compaction occurs only while TM0=1.
REQ-008 start  input  1  one-cycle pulse that begins a check session.
REQ-009 num_words  input  CNT_W  number of DATA_9 words to compact; sampled on start.
REQ-010 golden  input  WIDTH  expected signature; sampled on start.
REQ-011 data_valid  input  1  data_in is valid this cycle.
REQ-012 data_in  input  WIDTH  DATA_9 word from the s35932 DATA_9 output bus.
REQ-013 busy  output  1  session active (COMPACT or COMPARE).
REQ-014 done  output  1  one-cycle pulse when the verdict is valid.
REQ-015 pass  output  1  verdict, held until the next start.
REQ-016 signature  output  WIDTH  current MISR contents.

Function
REQ-017 The FSM SHALL have states IDLE, COMPACT, COMPARE and DONE.
REQ-018 IDLE SHALL load SEED into the MISR, latch num_words and golden, and clear pass on start=1, going to COMPACT, or to COMPARE if num_words=0.
REQ-019 COMPACT SHALL update the MISR on data_valid=1 && TM0=1 as next = {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ data_in.
REQ-020 COMPACT SHALL ignore data_valid while TM0=0: no MISR update and no count decrement.
REQ-021 Each accepted word SHALL decrement the remaining count, and acceptance of the last word SHALL move the FSM to COMPARE on the next cycle.
REQ-022 COMPARE SHALL last exactly one cycle, registering pass = (signature == golden) and moving to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 Latency from acceptance of the last word to done SHALL be 2 cycles.
REQ-025 start SHALL be ignored in every state other than IDLE.
REQ-026 start coincident with data_valid in IDLE SHALL not compact that word.
REQ-027 A num_words of all-ones SHALL compact 2^CNT_W-1 words, with no wrap-around of the count.
REQ-028 busy SHALL be 1 exactly in COMPACT and COMPARE.
REQ-029 signature SHALL hold its value in IDLE and DONE until the next start.

Reset
REQ-030 RESET=1 SHALL force IDLE, signature=SEED, count=0, busy=0, done=0 and pass=0 on the next CK edge.
REQ-031 RESET SHALL have priority over start and data_valid in every state.
REQ-032 A RESET during COMPACT SHALL abort the session with no done pulse.

Structure
REQ-033 A shared package s35932_pkg SHALL hold the FSM state enum, DEFAULT_POLY and DEFAULT_SEED.
REQ-034 The MISR datapath SHALL be one sub-module, s35932_misr, with ports CK, RESET, load, shift_en and data_in, plus parameters WIDTH, POLY and SEED.
REQ-035 The design SHALL contain no combinational path from any input to done or pass.

Verification
REQ-036 Zero words: start with num_words=0 and golden=32'hFFFFFFFF -> done 2 cycles later, pass=1, signature=32'hFFFFFFFF.
REQ-037 Single word: num_words=1, data_in=0, TM0=1, golden=32'hFB3EE249 -> pass=1; golden=32'h0 -> pass=0.
REQ-038 TM0 gating: num_words=4 and 6 valid words with TM0 low on the 2nd and 5th -> exactly 4 compacted, signature matches the reference model, done follows the 6th valid word (4th accepted) by 2 cycles.
REQ-039 Reset mid-session: RESET pulsed after 3 of 8 words -> no done, busy=0, signature=32'hFFFFFFFF on the next cycle; a new session then passes.
REQ-040 Back-to-back: start held high through DONE -> no re-entry until IDLE; a second start in IDLE begins a fresh session from SEED.
REQ-041 Random: 1000 sessions with random num_words in 0..64 and random data, with golden taken from the model and with 1 bit flipped -> pass=1 and pass=0 respectively in every case.
